id_ex_fwd_stage: RTL and testbench
==================================

Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core, merged with forwarding-select generation and load-use hazard detection.
- Captures decoded operands and control from ID.
- Pre-computes and registers the 2-bit forwarding selects that drive the EX-stage 3:1 operand muxes, so no compare logic sits in the EX critical path.
- Requests an IF/ID stall and inserts a bubble on load-use hazards, and counts inserted bubbles for debug.

Parameters:
- NB_DATA, 32, operand/PC/immediate width
- NB_REG, 5, register address width
- NB_CTRL, 12, width of opaque EX/MEM/WB control bundle passed through
- NB_CNT, 16, bubble counter width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_halt  in  1  global pipeline freeze (debug unit)
- i_flush  in  1  branch/jump resolved taken in EX; kill instruction entering EX
- i_valid  in  1  ID holds a real instruction
- i_pc  in  NB_DATA  ID PC
- i_rs1_addr, i_rs2_addr  in  NB_REG  source registers
- i_rs1_used, i_rs2_used  in  1  instruction actually reads rs1/rs2
- i_rs1_data, i_rs2_data  in  NB_DATA  register file read data (write-through regfile covers WB→ID)
- i_imm  in  NB_DATA  immediate
- i_rd_addr  in  NB_REG  destination
- i_reg_write, i_mem_read  in  1  ID control
- i_ctrl  in  NB_CTRL  remaining control
- i_exmem_rd  in  NB_REG  rd of instruction currently in EX/MEM
- i_exmem_reg_write  in  1  EX/MEM writes rd
- o_valid, o_pc, o_rs1_data, o_rs2_data, o_imm, o_rd_addr, o_reg_write, o_mem_read, o_ctrl  out  (as inputs)  registered EX-stage values
- o_fwd_a_sel, o_fwd_b_sel  out  2  EX mux selects
- o_load_use_stall  out  1  combinational; hold PC and IF/ID
- o_bubble_cnt  out  NB_CNT  saturating count of inserted bubbles

Behaviour:
- Reset (async, i_rst_n=0): every registered output is 0 (o_valid=0, o_reg_write=0, o_mem_read=0, selects 2'b00, o_bubble_cnt=0). Release is synchronous to the next i_clk edge.
- Select encoding: 2'b00 = register file, 2'b01 = MEM/WB result, 2'b10 = EX/MEM result. 2'b11 is never produced.
- Select generation (combinational in ID, registered with the instruction). For each source rsX with rsX_used=1 and rsX≠0:
  - If o_valid & o_reg_write & o_rd_addr==rsX → 2'b10 (current EX instruction will be in EX/MEM).
  - Else if i_exmem_reg_write & i_exmem_rd==rsX → 2'b01.
  - Else 2'b00.
  - The youngest producer wins when both match. rsX_used=0 or rsX=0 always gives 2'b00.
- Load-use:
  - o_load_use_stall = i_valid & o_valid & o_mem_read & o_rd_addr≠0 & ((i_rs1_used & rs1==o_rd_addr) | (i_rs2_used & rs2==o_rd_addr)).
  - Purely combinational from current state.
  - It is forced to 0 when i_flush=1, because the ID instruction is being killed.
- Register update priority each rising edge:
  1. i_halt=1: hold all registers, counter unchanged. This includes during i_flush or a stall.
  2. i_flush=1: load bubble.
  3. o_load_use_stall=1: load bubble.
  4. Otherwise: load ID values and computed selects.
- Bubble definition: o_valid=0, o_reg_write=0, o_mem_read=0, o_ctrl=0, selects 00. Data fields are don't-care but are cleared to 0.
- Latency: 1 cycle ID→EX. A load-use costs exactly one bubble. On the following cycle the load sits in EX/MEM, so the dependent instruction is captured with sel 2'b01.
- o_bubble_cnt increments by 1 on each bubble load triggered by flush or load-use, saturating at all-ones. A bubble caused by i_valid=0 is not counted.
- Reset mid-operation clears everything immediately, with no partial state.

Decomposition:
- Shared constants header/package cpu_pkg:
  - FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10.
  - NB_REG and NB_DATA defaults.
- Sub-module fwd_sel_gen (combinational): one instance per source operand. Inputs are rs, rs_used, the ID/EX rd/valid/reg_write and the EX/MEM rd/reg_write. Output is the 2-bit select.
- Hazard logic and the counter live in the top.

Test Plan:
- `add x5,x1,x2` in EX, then ID `sub x6,x5,x3` → next cycle o_fwd_a_sel=10, o_fwd_b_sel=00, no stall.
- Both ID/EX and EX/MEM write x5, ID reads x5 on rs1 and rs2 → both sels 10. With only EX/MEM writing x5 → both 01.
- `lw x7,0(x1)` in EX, ID `add x8,x7,x0` → o_load_use_stall=1. Next edge loads a bubble (o_valid=0) and o_bubble_cnt=1. Following edge captures the add with o_fwd_a_sel=01.
- Load-use with i_rs2_used=0, x0 as destination, or rd matching only an unused source → no stall, sels 00.
- i_flush=1 with a load-use present → bubble, stall low, counter +1. i_halt=1 for 3 cycles with flush asserted → all outputs frozen, counter unchanged.
- Force the counter to 0xFFFF and then inject 2 flushes → counter stays 0xFFFF. Assert i_rst_n=0 mid-run → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the RV32I pipeline: default widths and the encoding
// of the EX-stage operand forwarding selects.
package cpu_pkg;

  localparam int NB_DATA_DFLT = 32;
  localparam int NB_REG_DFLT  = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/fwd_sel_gen.sv
// Forwarding select for one source operand, computed in ID so that EX only
// sees a registered 2-bit mux select.
module fwd_sel_gen
  import cpu_pkg::*;
#(
  parameter int NB_REG = NB_REG_DFLT
) (
  input  logic [NB_REG-1:0] i_rs,
  input  logic              i_rs_used,
  input  logic              i_idex_valid,
  input  logic              i_idex_reg_write,
  input  logic [NB_REG-1:0] i_idex_rd,
  input  logic              i_exmem_reg_write,
  input  logic [NB_REG-1:0] i_exmem_rd,
  output logic [1:0]        o_sel
);

  // The instruction now in EX will sit in EX/MEM next cycle, so it is the
  // youngest producer and takes precedence over the one now in EX/MEM.
  always_comb begin
    o_sel = FWD_RF;
    if (i_rs_used && (i_rs != '0)) begin
      if (i_idex_valid && i_idex_reg_write && (i_idex_rd == i_rs)) begin
        o_sel = FWD_EXMEM;
      end else if (i_exmem_reg_write && (i_exmem_rd == i_rs)) begin
        o_sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with registered forwarding selects, load-use
// stall/bubble insertion and a saturating bubble counter for debug.
module id_ex_fwd_stage
  import cpu_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DFLT,
  parameter int NB_REG  = NB_REG_DFLT,
  parameter int NB_CTRL = 12,
  parameter int NB_CNT  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_halt,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic [NB_REG-1:0]  i_rs1_addr,
  input  logic [NB_REG-1:0]  i_rs2_addr,
  input  logic               i_rs1_used,
  input  logic               i_rs2_used,
  input  logic [NB_DATA-1:0] i_rs1_data,
  input  logic [NB_DATA-1:0] i_rs2_data,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [NB_REG-1:0]  i_rd_addr,
  input  logic               i_reg_write,
  input  logic               i_mem_read,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic [NB_REG-1:0]  i_exmem_rd,
  input  logic               i_exmem_reg_write,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_pc,
  output logic [NB_DATA-1:0] o_rs1_data,
  output logic [NB_DATA-1:0] o_rs2_data,
  output logic [NB_DATA-1:0] o_imm,
  output logic [NB_REG-1:0]  o_rd_addr,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [1:0]         o_fwd_a_sel,
  output logic [1:0]         o_fwd_b_sel,
  output logic               o_load_use_stall,
  output logic [NB_CNT-1:0]  o_bubble_cnt
);

  logic               valid_q,      valid_d;
  logic [NB_DATA-1:0] pc_q,         pc_d;
  logic [NB_DATA-1:0] rs1_data_q,   rs1_data_d;
  logic [NB_DATA-1:0] rs2_data_q,   rs2_data_d;
  logic [NB_DATA-1:0] imm_q,        imm_d;
  logic [NB_REG-1:0]  rd_addr_q,    rd_addr_d;
  logic               reg_write_q,  reg_write_d;
  logic               mem_read_q,   mem_read_d;
  logic [NB_CTRL-1:0] ctrl_q,       ctrl_d;
  logic [1:0]         fwd_a_sel_q,  fwd_a_sel_d;
  logic [1:0]         fwd_b_sel_q,  fwd_b_sel_d;
  logic [NB_CNT-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic [NB_REG-1:0]  rs_addr [2];
  logic               rs_used [2];
  logic [1:0]         fwd_sel [2];
  logic               load_use;

  assign rs_addr[0] = i_rs1_addr;
  assign rs_addr[1] = i_rs2_addr;
  assign rs_used[0] = i_rs1_used;
  assign rs_used[1] = i_rs2_used;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_sel_gen #(.NB_REG(NB_REG)) u_fwd_sel_gen (
      .i_rs              (rs_addr[gi]),
      .i_rs_used         (rs_used[gi]),
      .i_idex_valid      (valid_q),
      .i_idex_reg_write  (reg_write_q),
      .i_idex_rd         (rd_addr_q),
      .i_exmem_reg_write (i_exmem_reg_write),
      .i_exmem_rd        (i_exmem_rd),
      .o_sel             (fwd_sel[gi])
    );
  end

  // A flushed ID instruction is being killed, so it cannot cause a stall.
  assign load_use = i_valid && valid_q && mem_read_q && (rd_addr_q != '0) && !i_flush &&
                    ((i_rs1_used && (i_rs1_addr == rd_addr_q)) ||
                     (i_rs2_used && (i_rs2_addr == rd_addr_q)));

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rd_addr_d    = rd_addr_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    ctrl_d       = ctrl_q;
    fwd_a_sel_d  = fwd_a_sel_q;
    fwd_b_sel_d  = fwd_b_sel_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!i_halt) begin
      if (i_flush || load_use || !i_valid) begin
        valid_d     = 1'b0;
        pc_d        = '0;
        rs1_data_d  = '0;
        rs2_data_d  = '0;
        imm_d       = '0;
        rd_addr_d   = '0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        ctrl_d      = '0;
        fwd_a_sel_d = FWD_RF;
        fwd_b_sel_d = FWD_RF;
        // Empty ID slots are not hazards and stay out of the count.
        if ((i_flush || load_use) && (bubble_cnt_q != '1)) begin
          bubble_cnt_d = bubble_cnt_q + NB_CNT'(1);
        end
      end else begin
        valid_d     = 1'b1;
        pc_d        = i_pc;
        rs1_data_d  = i_rs1_data;
        rs2_data_d  = i_rs2_data;
        imm_d       = i_imm;
        rd_addr_d   = i_rd_addr;
        reg_write_d = i_reg_write;
        mem_read_d  = i_mem_read;
        ctrl_d      = i_ctrl;
        fwd_a_sel_d = fwd_sel[0];
        fwd_b_sel_d = fwd_sel[1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rd_addr_q    <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      ctrl_q       <= '0;
      fwd_a_sel_q  <= FWD_RF;
      fwd_b_sel_q  <= FWD_RF;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rd_addr_q    <= rd_addr_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      ctrl_q       <= ctrl_d;
      fwd_a_sel_q  <= fwd_a_sel_d;
      fwd_b_sel_q  <= fwd_b_sel_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_valid          = valid_q;
  assign o_pc             = pc_q;
  assign o_rs1_data       = rs1_data_q;
  assign o_rs2_data       = rs2_data_q;
  assign o_imm            = imm_q;
  assign o_rd_addr        = rd_addr_q;
  assign o_reg_write      = reg_write_q;
  assign o_mem_read       = mem_read_q;
  assign o_ctrl           = ctrl_q;
  assign o_fwd_a_sel      = fwd_a_sel_q;
  assign o_fwd_b_sel      = fwd_b_sel_q;
  assign o_load_use_stall = load_use;
  assign o_bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Bench for id_ex_fwd_stage: directed vector table, random run against a
// pipeline-level reference model, counter saturation and async reset.
module tb_id_ex_fwd_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt, flush, valid;
  logic [31:0] pc, rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd, exmem_rd;
  logic        rs1_used, rs2_used, reg_write, mem_read, exmem_we;
  logic [11:0] ctrl;
  logic        o_valid, o_reg_write, o_mem_read, o_stall;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0]  o_rd;
  logic [11:0] o_ctrl;
  logic [1:0]  o_fa, o_fb;
  logic [15:0] o_cnt;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_fwd_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_halt(halt), .i_flush(flush), .i_valid(valid),
    .i_pc(pc), .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rs1_used(rs1_used),
    .i_rs2_used(rs2_used), .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_imm(imm),
    .i_rd_addr(rd), .i_reg_write(reg_write), .i_mem_read(mem_read), .i_ctrl(ctrl),
    .i_exmem_rd(exmem_rd), .i_exmem_reg_write(exmem_we),
    .o_valid(o_valid), .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_imm(o_imm), .o_rd_addr(o_rd), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
    .o_ctrl(o_ctrl), .o_fwd_a_sel(o_fa), .o_fwd_b_sel(o_fb),
    .o_load_use_stall(o_stall), .o_bubble_cnt(o_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vectors: ID instruction + hazard controls, expected stall
  // (before the edge) and expected EX-side values (after the edge).
  typedef struct {
    logic v; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
    logic [4:0] rd; logic rw; logic mr; logic fl; logic hl;
    logic [4:0] emrd; logic emw;
    logic e_stall; logic e_valid; logic [1:0] e_fa; logic [1:0] e_fb; logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mkv(logic v, logic [4:0] a, logic [4:0] b, logic u1, logic u2,
                               logic [4:0] d, logic rw, logic mr, logic fl, logic hl,
                               logic [4:0] emrd, logic emw, logic es, logic ev,
                               logic [1:0] fa, logic [1:0] fb, logic [15:0] cnt);
    vec_t r;
    r.v = v; r.rs1 = a; r.rs2 = b; r.u1 = u1; r.u2 = u2; r.rd = d; r.rw = rw; r.mr = mr;
    r.fl = fl; r.hl = hl; r.emrd = emrd; r.emw = emw;
    r.e_stall = es; r.e_valid = ev; r.e_fa = fa; r.e_fb = fb; r.e_cnt = cnt;
    return r;
  endfunction

  // Reference model: the instruction currently held in EX.
  typedef struct {
    logic valid; logic [31:0] pc; logic [31:0] d1; logic [31:0] d2; logic [31:0] imm;
    logic [4:0] rd; logic rw; logic mr; logic [11:0] ctrl; logic [1:0] fa; logic [1:0] fb;
  } ex_t;

  ex_t m_ex;
  int  m_cnt;

  function automatic logic [1:0] ref_sel(logic [4:0] rs, logic used);
    if (!used || rs == 5'd0) return 2'b00;
    if (m_ex.valid && m_ex.rw && m_ex.rd == rs) return 2'b10;
    if (exmem_we && exmem_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_stall();
    if (flush || !valid || !m_ex.valid || !m_ex.mr || m_ex.rd == 5'd0) return 1'b0;
    return (rs1_used && rs1 == m_ex.rd) || (rs2_used && rs2 == m_ex.rd);
  endfunction

  task automatic idle_inputs();
    halt = 0; flush = 0; valid = 0; pc = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    rs1_data = 0; rs2_data = 0; imm = 0; rd = 0; reg_write = 0; mem_read = 0; ctrl = 0;
    exmem_rd = 0; exmem_we = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    m_ex = '{default: '0};
    m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, o_valid, m_ex.valid);
    chk({tag, ".cnt"}, o_cnt, m_cnt);
    if (m_ex.valid) begin
      chk({tag, ".pc"}, o_pc, m_ex.pc);
      chk({tag, ".d1"}, o_rs1_data, m_ex.d1);
      chk({tag, ".d2"}, o_rs2_data, m_ex.d2);
      chk({tag, ".imm"}, o_imm, m_ex.imm);
      chk({tag, ".rd"}, o_rd, m_ex.rd);
      chk({tag, ".rw"}, o_reg_write, m_ex.rw);
      chk({tag, ".mr"}, o_mem_read, m_ex.mr);
      chk({tag, ".ctrl"}, o_ctrl, m_ex.ctrl);
      chk({tag, ".fa"}, o_fa, m_ex.fa);
      chk({tag, ".fb"}, o_fb, m_ex.fb);
    end else begin
      chk({tag, ".bub_rw"}, o_reg_write, 1'b0);
      chk({tag, ".bub_mr"}, o_mem_read, 1'b0);
      chk({tag, ".bub_sel"}, {o_fa, o_fb}, 4'b0000);
    end
  endtask

  vec_t tbl [17];

  initial begin
    tbl[0]  = mkv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
    tbl[1]  = mkv(1, 5, 3, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0);
    tbl[2]  = mkv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
    tbl[3]  = mkv(1, 5, 5, 1, 1, 10, 1, 0, 0, 0, 5, 1, 0, 1, 2'b10, 2'b10, 0);
    tbl[4]  = mkv(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 5, 1, 0, 1, 2'b01, 2'b01, 0);
    tbl[5]  = mkv(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
    tbl[6]  = mkv(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1);
    tbl[7]  = mkv(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, 7, 1, 0, 1, 2'b01, 2'b00, 1);
    tbl[8]  = mkv(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1);
    tbl[9]  = mkv(1, 3, 7, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1);
    tbl[10] = mkv(1, 0, 0, 1, 1, 11, 1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1);
    tbl[11] = mkv(1, 11, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2);
    tbl[12] = mkv(1, 1, 0, 1, 0, 12, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2);
    tbl[13] = mkv(1, 12, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2);
    tbl[14] = mkv(1, 12, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2);
    tbl[15] = mkv(1, 12, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2);
    tbl[16] = mkv(1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2);

    rst_n = 0;
    idle_inputs();
    #2;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_sel", {o_fa, o_fb}, 4'b0000);
    chk("rst_cnt", o_cnt, 16'd0);
    do_reset();
    chk("rel_valid", o_valid, 1'b0);
    chk("rel_ctrl", {o_reg_write, o_mem_read, o_ctrl}, 14'd0);

    // Directed table
    for (int i = 0; i < 17; i++) begin
      valid = tbl[i].v; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      rs1_used = tbl[i].u1; rs2_used = tbl[i].u2; rd = tbl[i].rd;
      reg_write = tbl[i].rw; mem_read = tbl[i].mr; flush = tbl[i].fl; halt = tbl[i].hl;
      exmem_rd = tbl[i].emrd; exmem_we = tbl[i].emw;
      #1;
      chk($sformatf("vec%0d.stall", i), o_stall, tbl[i].e_stall);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.valid", i), o_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d.fa", i), o_fa, tbl[i].e_fa);
      chk($sformatf("vec%0d.fb", i), o_fb, tbl[i].e_fb);
      chk($sformatf("vec%0d.cnt", i), o_cnt, tbl[i].e_cnt);
      $display("vec %0d: rs1=%0d rs2=%0d rd=%0d fl=%0d hl=%0d -> valid=%0d fa=%0d fb=%0d cnt=%0d",
               i, rs1, rs2, rd, flush, halt, o_valid, o_fa, o_fb, o_cnt);
    end

    // Random run against the reference model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      ex_t nxt;
      logic st;
      valid = ($urandom_range(7) != 0);
      halt = ($urandom_range(9) == 0);
      flush = ($urandom_range(7) == 0);
      rs1 = 5'($urandom_range(7)); rs2 = 5'($urandom_range(7)); rd = 5'($urandom_range(7));
      rs1_used = ($urandom_range(3) != 0); rs2_used = ($urandom_range(2) != 0);
      reg_write = ($urandom_range(3) != 0); mem_read = ($urandom_range(2) == 0);
      exmem_rd = 5'($urandom_range(7)); exmem_we = $urandom_range(1) == 1;
      pc = $urandom; rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
      ctrl = 12'($urandom);
      #1;
      st = ref_stall();
      chk($sformatf("rnd%0d.stall", k), o_stall, st);
      nxt = m_ex;
      if (!halt) begin
        if (flush || st || !valid) begin
          nxt = '{default: '0};
          if ((flush || st) && m_cnt < 65535) m_cnt++;
        end else begin
          nxt = '{valid: 1'b1, pc: pc, d1: rs1_data, d2: rs2_data, imm: imm, rd: rd,
                  rw: reg_write, mr: mem_read, ctrl: ctrl,
                  fa: ref_sel(rs1, rs1_used), fb: ref_sel(rs2, rs2_used)};
        end
      end
      @(posedge clk);
      #1;
      m_ex = nxt;
      check_all($sformatf("rnd%0d", k));
      $display("rnd %0d: v=%0d h=%0d f=%0d st=%0d -> valid=%0d rd=%0d fa=%0d fb=%0d cnt=%0d",
               k, valid, halt, flush, st, o_valid, o_rd, o_fa, o_fb, o_cnt);
    end

    // Counter saturation
    do_reset();
    flush = 1; valid = 1;
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_full", o_cnt, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_hold", o_cnt, 16'hFFFF);
    chk("sat_valid", o_valid, 1'b0);
    $display("sat: 65537 flushes -> cnt=%0h", o_cnt);

    // Async reset in the middle of a cycle
    flush = 0; valid = 1; rd = 9; reg_write = 1; mem_read = 1; pc = 32'h1234; ctrl = 12'hABC;
    rs1 = 9; rs1_used = 1; exmem_rd = 9; exmem_we = 1;
    @(posedge clk);
    #1;
    chk("pre_rst_valid", o_valid, 1'b1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_pc", o_pc, 32'd0);
    chk("arst_ctl", {o_reg_write, o_mem_read, o_ctrl, o_rd}, 19'd0);
    chk("arst_sel", {o_fa, o_fb}, 4'b0000);
    chk("arst_cnt", o_cnt, 16'd0);
    chk("arst_stall", o_stall, 1'b0);
    $display("arst: valid=%0d cnt=%0d", o_valid, o_cnt);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
